sa_ram_rd_streamer_32x544: RTL and testbench

- Read-side controller for the 32x544 read/write-separate SA RAM model (1-cycle registered read address, data on dout the cycle after re).
- Accepts a burst command (start address, word count) and drives the RAM read port.
- Captures each returned word into a 3-entry buffer and presents it as a valid/ready stream with a last flag.
- The write side of the same RAM is owned by the producer; this block never drives wa/we/di.

---
 rtl/sa_ram_pkg.sv | 14 +
 rtl/sa_ram_rd_skid_fifo.sv | 55 +++++
 rtl/sa_ram_rd_streamer_32x544.sv | 115 +++++++++++
 tb/tb_sa_ram_rd_streamer_32x544.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sa_ram_pkg.sv
// Shared constants and types for the SA RAM read-side streamer.
package sa_ram_pkg;
  localparam int SA_AW        = 5;
  localparam int SA_DW        = 544;
  localparam int SA_LENW      = 6;
  localparam int SA_BUF_DEPTH = 3;
  localparam int SA_MAX_LEN   = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;
endpackage

// File: rtl/sa_ram_rd_skid_fifo.sv
// Three-entry in-order FIFO holding returned RAM words plus their last tag.
module sa_ram_rd_skid_fifo
  import sa_ram_pkg::*;
#(
  parameter int W = SA_DW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [0:SA_BUF_DEPTH-1];
  logic [1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == 2'(SA_BUF_DEPTH - 1)) ? 2'd0 : wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == 2'(SA_BUF_DEPTH - 1)) ? 2'd0 : rd_ptr_q + 2'd1;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Storage carries no reset; only the occupancy bookkeeping is cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/sa_ram_rd_streamer_32x544.sv
// Burst read controller for the 32x544 SA RAM: issues reads under a 3-word
// credit limit and streams returned words out as valid/ready beats with last.
module sa_ram_rd_streamer_32x544
  import sa_ram_pkg::*;
#(
  parameter int AW   = SA_AW,
  parameter int DW   = SA_DW,
  parameter int LENW = SA_LENW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LENW-1:0] cmd_len,
  output logic            ram_re,
  output logic [AW-1:0]   ram_ra,
  input  logic [DW-1:0]   ram_dout,
  output logic [31:0]     pwrbus_ram_pd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LENW-1:0] rem_q, rem_d;
  logic            inflight_q, inflight_d;
  logic            inflight_last_q, inflight_last_d;

  logic [DW:0]     head;
  logic [1:0]      buf_count;
  logic [2:0]      in_use;
  logic            pop;

  // Credit counts only registered state so out_ready never reaches ram_re.
  assign in_use = {1'b0, buf_count} + {2'b00, inflight_q};
  assign ram_re = (state_q == ISSUE) && (in_use < 3'(SA_BUF_DEPTH));
  assign ram_ra = addr_q;

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign pwrbus_ram_pd = 32'd0;

  assign out_valid = (buf_count != 2'd0);
  assign out_data  = out_valid ? head[DW-1:0] : '0;
  assign out_last  = out_valid & head[DW];
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    inflight_d      = ram_re;
    inflight_last_d = ram_re && (rem_q == LENW'(1));
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_len != '0) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ram_re) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - LENW'(1);
          if (rem_q == LENW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  sa_ram_rd_skid_fifo #(
    .W (DW + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({inflight_last_q, ram_dout}),
    .pop       (pop),
    .pop_data  (head),
    .count     (buf_count)
  );

  a_cmd_len_legal : assert property (@(posedge clk) disable iff (rst)
    (cmd_valid && cmd_ready) |-> (cmd_len <= LENW'(SA_MAX_LEN)));

endmodule

// File: tb/tb_sa_ram_rd_streamer_32x544.sv
// Directed bench for the SA RAM read streamer with a behavioural RAM model.
module tb_sa_ram_rd_streamer_32x544;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [4:0]   cmd_addr;
  logic [5:0]   cmd_len;
  logic         ram_re;
  logic [4:0]   ram_ra;
  logic [543:0] ram_dout;
  logic [31:0]  pwrbus_ram_pd;
  logic         out_valid;
  logic         out_ready;
  logic [543:0] out_data;
  logic         out_last;
  logic         busy;

  logic [543:0] mem [0:31];
  int           pass_cnt;
  int           total_cnt;

  sa_ram_rd_streamer_32x544 dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .ram_re        (ram_re),
    .ram_ra        (ram_ra),
    .ram_dout      (ram_dout),
    .pwrbus_ram_pd (pwrbus_ram_pd),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, data on dout the cycle after re.
  initial ram_dout = '0;
  always @(posedge clk) begin
    if (ram_re) ram_dout <= mem[ram_ra];
  end

  function automatic logic [543:0] word(input int i);
    logic [4:0] a;
    a = i[4:0];
    return {a, 534'b0, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [543:0] obs, input logic [543:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " cmd_ready"}, cmd_ready, 1);
    chk({tag, " ram_re"}, ram_re, 0);
    chk({tag, " ram_ra"}, ram_ra, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_data"}, out_data, 0);
    chk({tag, " out_last"}, out_last, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " pwrbus"}, pwrbus_ram_pd, 0);
  endtask

  // mode 0: always ready, 1: stall cycles 3..12, 2: random 50% ready
  task automatic run_burst(input int addr, input int len, input int mode, input string tag);
    int issued;
    int popped;
    int c;
    issued = 0;
    popped = 0;
    cmd_valid = 1'b1;
    cmd_addr  = addr[4:0];
    cmd_len   = len[5:0];
    out_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    c = 1;
    while (popped < len && c < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(c >= 3 && c < 13);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      chk({tag, " credit"}, (issued - popped <= 3), 1);
      if (ram_re) begin
        chk({tag, " ram_ra"}, ram_ra, (addr + issued) % 32);
        issued++;
      end
      if (out_valid && out_ready) begin
        chk({tag, " data"}, out_data, word((addr + popped) % 32));
        chk({tag, " last"}, out_last, (popped == len - 1));
        popped++;
      end else if (!out_valid) begin
        chk({tag, " idle_data"}, {out_last, out_data}, 0);
      end
      if (mode == 1 && c == 12) begin
        chk({tag, " stall_issued"}, issued, 3);
        chk({tag, " stall_popped"}, popped, 0);
      end
      step();
      c++;
    end
    chk({tag, " beats"}, popped, len);
    chk({tag, " issued"}, issued, len);
    chk({tag, " end_cmd_ready"}, cmd_ready, 1);
    chk({tag, " end_busy"}, busy, 0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    for (int i = 0; i < 32; i++) mem[i] = word(i);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
    step();
    step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // len 4 from addr 2: exact cycle timing
    cmd_valid = 1'b1;
    cmd_addr  = 5'd2;
    cmd_len   = 6'd4;
    out_ready = 1'b1;
    chk("t1 c0 cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("t1 c%0d ram_re", c), ram_re, (c <= 4));
      if (c <= 4) chk($sformatf("t1 c%0d ram_ra", c), ram_ra, c + 1);
      chk($sformatf("t1 c%0d out_valid", c), out_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk($sformatf("t1 c%0d data", c), out_data, word(c - 1));
      chk($sformatf("t1 c%0d out_last", c), out_last, (c == 6));
      chk($sformatf("t1 c%0d cmd_ready", c), cmd_ready, (c == 7));
      chk($sformatf("t1 c%0d busy", c), busy, (c != 7));
      step();
    end

    run_burst(30, 4, 0, "wrap");
    run_burst(0, 8, 1, "bp");

    // zero-length command is consumed without any activity
    cmd_valid = 1'b1;
    cmd_addr  = 5'd5;
    cmd_len   = 6'd0;
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("len0 ram_re", ram_re, 0);
      chk("len0 out_valid", out_valid, 0);
      chk("len0 cmd_ready", cmd_ready, 1);
      chk("len0 busy", busy, 0);
      step();
    end

    run_burst(17, 32, 2, "rand32");

    // abort mid-burst
    cmd_valid = 1'b1;
    cmd_addr  = 5'd0;
    cmd_len   = 6'd16;
    out_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    step();
    chk("abort c4 ram_re", ram_re, 1);
    rst = 1'b1;
    step();
    chk_reset_outputs("abort");
    rst = 1'b0;
    step();
    chk("abort discard out_valid", out_valid, 0);
    chk("abort discard busy", busy, 0);
    run_burst(9, 2, 0, "post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
